// File: rtl/dog_hessian_window_if.sv
//-----------------------------------------------------------------------------
// dog_hessian_window_if
// Stream bundle between a DoG pixel source, the Hessian window stage and the
// edge-rejection consumer.
//   ivalid/isof/ipix : raster-order DoG pixel stream into the stage
//   ovalid/oeof      : Hessian result strobe / last interior pixel of frame
//   odxx/odyy/odxy   : saturated signed 9-bit Hessian terms
//   ox/oy            : centre-pixel column / row of the result
// Modports: master = pixel producer / result consumer, slave = the stage.
// Revision: 1.0
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface dog_hessian_window_if #(
  parameter int COORD_W = 10
);
  logic                      ivalid;
  logic                      isof;
  logic signed [8:0]         ipix;
  logic                      ovalid;
  logic                      oeof;
  logic signed [8:0]         odxx;
  logic signed [8:0]         odyy;
  logic signed [8:0]         odxy;
  logic [COORD_W-1:0]        ox;
  logic [COORD_W-1:0]        oy;

  modport master (
    output ivalid, isof, ipix,
    input  ovalid, oeof, odxx, odyy, odxy, ox, oy
  );

  modport slave (
    input  ivalid, isof, ipix,
    output ovalid, oeof, odxx, odyy, odxy, ox, oy
  );
endinterface

`default_nettype wire

// File: rtl/dog_hessian_window.sv
//-----------------------------------------------------------------------------
// dog_hessian_window
// Buffers two DoG lines to build a 3x3 window and emits saturated Hessian
// terms (dxx, dyy, dxy) for every interior pixel, two cycles after the pixel
// that completes the window.
// Ports:
//   iclk  : clock, rising edge
//   irst  : synchronous active-high reset
//   bus   : dog_hessian_window_if.slave (pixel stream in, Hessian results out)
// Revision: 1.0
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module dog_hessian_window #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int COORD_W = 10
) (
  input  wire logic              iclk,
  input  wire logic              irst,
  dog_hessian_window_if.slave    bus
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COORD_W-1:0] C_COL_MAX = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] C_ROW_MAX = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] C_ONE     = COORD_W'(1);
  localparam logic [COORD_W-1:0] C_TWO     = COORD_W'(2);

  function automatic logic signed [11:0] sx(input logic signed [8:0] v);
    return {{3{v[8]}}, v};
  endfunction

  function automatic logic signed [8:0] sat9(input logic signed [11:0] v);
    if (v > 12'sd255)       return 9'sd255;
    else if (v < -12'sd256) return 9'h100;
    else                    return v[8:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Raster position. isof overrides the counters so the current pixel is (0,0).
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] col_q, row_q, col_d, row_d;
  logic [COORD_W-1:0] cur_col, cur_row;

  always_comb begin
    cur_col = bus.isof ? '0 : col_q;
    cur_row = bus.isof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (bus.ivalid) begin
      if (cur_col == C_COL_MAX) begin
        col_d = '0;
        row_d = (cur_row == C_ROW_MAX) ? '0 : cur_row + C_ONE;
      end else begin
        col_d = cur_col + C_ONE;
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: lb1 holds row-1, lb0 holds row-2. Contents are not reset;
  // stale entries only ever feed border windows, which are suppressed.
  // ---------------------------------------------------------------------------
  logic signed [8:0] lb0_q [IMG_W];
  logic signed [8:0] lb1_q [IMG_W];
  logic [AW-1:0]     lb_addr;
  logic signed [8:0] lb0_rd, lb1_rd;

  assign lb_addr = cur_col[AW-1:0];
  assign lb0_rd  = lb0_q[lb_addr];
  assign lb1_rd  = lb1_q[lb_addr];

  always_ff @(posedge iclk) begin
    if (bus.ivalid && !irst) begin
      lb0_q[lb_addr] <= lb1_rd;
      lb1_q[lb_addr] <= bus.ipix;
    end
  end

  // ---------------------------------------------------------------------------
  // 3x3 window, row 0 oldest, column 0 oldest. win_d is the window including
  // the incoming column; S1 sums are taken from it directly so the result
  // lands two cycles after the completing pixel.
  // ---------------------------------------------------------------------------
  logic signed [8:0] win_q [3][3];
  logic signed [8:0] win_d [3][3];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb0_rd;
    win_d[1][2] = lb1_rd;
    win_d[2][2] = bus.ipix;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else if (bus.ivalid) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= win_d[r][c];
    end
  end

  // ---------------------------------------------------------------------------
  // Raw sums in 12-bit signed; range is +/-1022 so no overflow is possible.
  // ---------------------------------------------------------------------------
  logic signed [11:0] dxx_sum, dyy_sum, dxy_sum;
  logic               win_done;
  logic               win_last;

  always_comb begin
    dxx_sum  = sx(win_d[1][2]) + sx(win_d[1][0]) - (sx(win_d[1][1]) <<< 1);
    dyy_sum  = sx(win_d[2][1]) + sx(win_d[0][1]) - (sx(win_d[1][1]) <<< 1);
    dxy_sum  = sx(win_d[2][2]) - sx(win_d[2][0]) - sx(win_d[0][2]) + sx(win_d[0][0]);
    win_done = bus.ivalid && (cur_col >= C_TWO) && (cur_row >= C_TWO);
    win_last = (cur_col == C_COL_MAX) && (cur_row == C_ROW_MAX);
  end

  // S1: raw sums, valid and centre coordinates
  logic                s1_valid_q, s1_eof_q;
  logic [COORD_W-1:0]  s1_x_q, s1_y_q;
  logic signed [11:0]  s1_dxx_q, s1_dyy_q, s1_dxy_q;

  always_ff @(posedge iclk) begin
    if (irst) begin
      s1_valid_q <= 1'b0;
      s1_eof_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_dxx_q   <= '0;
      s1_dyy_q   <= '0;
      s1_dxy_q   <= '0;
    end else begin
      s1_valid_q <= win_done;
      if (win_done) begin
        s1_eof_q <= win_last;
        s1_x_q   <= cur_col - C_ONE;
        s1_y_q   <= cur_row - C_ONE;
        s1_dxx_q <= dxx_sum;
        s1_dyy_q <= dyy_sum;
        s1_dxy_q <= dxy_sum;
      end
    end
  end

  // S2: quarter-scale dxy (floor via arithmetic shift) and saturation
  logic                ovalid_q, oeof_q;
  logic [COORD_W-1:0]  ox_q, oy_q;
  logic signed [8:0]   odxx_q, odyy_q, odxy_q;

  always_ff @(posedge iclk) begin
    if (irst) begin
      ovalid_q <= 1'b0;
      oeof_q   <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
      odxx_q   <= '0;
      odyy_q   <= '0;
      odxy_q   <= '0;
    end else begin
      ovalid_q <= s1_valid_q;
      oeof_q   <= s1_valid_q && s1_eof_q;
      if (s1_valid_q) begin
        ox_q   <= s1_x_q;
        oy_q   <= s1_y_q;
        odxx_q <= sat9(s1_dxx_q);
        odyy_q <= sat9(s1_dyy_q);
        odxy_q <= sat9(s1_dxy_q >>> 2);
      end
    end
  end

  assign bus.ovalid = ovalid_q;
  assign bus.oeof   = oeof_q;
  assign bus.ox     = ox_q;
  assign bus.oy     = oy_q;
  assign bus.odxx   = odxx_q;
  assign bus.odyy   = odyy_q;
  assign bus.odxy   = odxy_q;

endmodule

`default_nettype wire

// File: tb/tb_dog_hessian_window.sv
//-----------------------------------------------------------------------------
// tb_dog_hessian_window
// Directed-vector bench for dog_hessian_window on an 8x6 image. The driver
// pushes hand-derived expected results into a scoreboard queue as pixels are
// issued; an independent monitor pops and compares on every ovalid strobe.
// Revision: 1.0
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dog_hessian_window;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dog_hessian_window_if #(.COORD_W(CW)) bus ();

  dog_hessian_window #(.IMG_W(W), .IMG_H(H), .COORD_W(CW)) dut (
    .iclk (clk),
    .irst (rst),
    .bus  (bus)
  );

  typedef struct {
    int x;
    int y;
    int dxx;
    int dyy;
    int dxy;
    bit eof;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_tests    = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  int   mode       = 0;
  int   tx         = 0;
  int   ty         = 0;
  int   ovalid_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: constant 37, 1: x*y, 2: x^2, 3: checkerboard 255/-256
  function automatic int pix(int m, int x, int y);
    case (m)
      0:       return 37;
      1:       return x * y;
      2:       return x * x;
      default: return (((x + y) % 2) == 0) ? 255 : -256;
    endcase
  endfunction

  // Hand-derived Hessian terms for each pattern at centre (cx,cy)
  task automatic exp_vals(input int m, input int cx, input int cy,
                          output int dxx, output int dyy, output int dxy);
    case (m)
      0: begin dxx = 0; dyy = 0; dxy = 0; end
      1: begin dxx = 0; dyy = 0; dxy = 1; end
      2: begin dxx = 2; dyy = 0; dxy = 0; end
      default: begin
        if (((cx + cy) % 2) == 0) begin dxx = -256; dyy = -256; end
        else                      begin dxx = 255;  dyy = 255;  end
        dxy = 0;
      end
    endcase
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every strobe against the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.ovalid === 1'b1) begin
        ovalid_cnt++;
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ovalid: got ox=%0d oy=%0d, expected none", bus.ox, bus.oy);
        end else begin
          e = sbq.pop_front();
          check("ox",      int'(bus.ox), e.x);
          check("oy",      int'(bus.oy), e.y);
          check("odxx",    int'(bus.odxx), e.dxx);
          check("odyy",    int'(bus.odyy), e.dyy);
          check("odxy",    int'(bus.odxy), e.dxy);
          check("oeof",    int'(bus.oeof), int'(e.eof));
          check("latency", cyc, e.cyc);
        end
      end else begin
        if (bus.oeof !== 1'b0) check("oeof_idle", int'(bus.oeof), 0);
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          e = sbq.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL missing_ovalid: got none, expected centre (%0d,%0d) at cycle %0d", e.x, e.y, e.cyc);
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    bus.ivalid = 1'b0;
    bus.isof   = 1'b0;
  endtask

  task automatic send(input bit sof, input bit gaps);
    exp_t e;
    if (gaps) while ($urandom_range(0, 99) < 40) idle();
    @(negedge clk);
    if (sof) begin tx = 0; ty = 0; end
    bus.ivalid = 1'b1;
    bus.isof   = sof;
    bus.ipix   = 9'(pix(mode, tx, ty));
    if (tx >= 2 && ty >= 2) begin
      e.x   = tx - 1;
      e.y   = ty - 1;
      exp_vals(mode, e.x, e.y, e.dxx, e.dyy, e.dxy);
      e.eof = (tx == W - 1) && (ty == H - 1);
      e.cyc = cyc + 2;
      sbq.push_back(e);
    end
    if (tx == W - 1) begin
      tx = 0;
      ty = (ty == H - 1) ? 0 : ty + 1;
    end else begin
      tx = tx + 1;
    end
  endtask

  task automatic frame(input bit sof_first, input bit gaps);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send(sof_first && x == 0 && y == 0, gaps);
  endtask

  task automatic check_reset_outputs();
    check("rst_ovalid", int'(bus.ovalid), 0);
    check("rst_oeof",   int'(bus.oeof), 0);
    check("rst_odxx",   int'(bus.odxx), 0);
    check("rst_odyy",   int'(bus.odyy), 0);
    check("rst_odxy",   int'(bus.odxy), 0);
    check("rst_ox",     int'(bus.ox), 0);
    check("rst_oy",     int'(bus.oy), 0);
  endtask

  // Assert reset together with a valid pixel (which must be dropped) and
  // discard scoreboard entries that would have emerged at or after the reset.
  task automatic pulse_reset();
    @(negedge clk);
    rst        = 1'b1;
    bus.ivalid = 1'b1;
    bus.isof   = 1'b0;
    bus.ipix   = 9'sd99;
    while (sbq.size() > 0 && sbq[sbq.size()-1].cyc >= cyc + 1) void'(sbq.pop_back());
    @(negedge clk);
    check_reset_outputs();
    rst        = 1'b0;
    bus.ivalid = 1'b0;
    tx = 0;
    ty = 0;
  endtask

  initial begin
    int c0;
    bus.ivalid = 1'b0;
    bus.isof   = 1'b0;
    bus.ipix   = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // Constant, x*y, x^2, checkerboard with continuous valid
    for (int m = 0; m < 4; m++) begin
      mode = m;
      c0 = ovalid_cnt;
      frame(1'b1, 1'b0);
      repeat (4) idle();
      check("frame_count", ovalid_cnt - c0, 24);
    end

    // x*y with random input gaps
    mode = 1;
    c0 = ovalid_cnt;
    frame(1'b1, 1'b1);
    repeat (4) idle();
    check("gap_frame_count", ovalid_cnt - c0, 24);

    // Reset mid row 3 (after pixel (3,3)), then a frame without isof
    c0 = ovalid_cnt;
    send(1'b1, 1'b0);
    while (!(tx == 4 && ty == 3)) send(1'b0, 1'b0);
    pulse_reset();
    frame(1'b0, 1'b0);
    repeat (4) idle();
    check("reset_frame_count", ovalid_cnt - c0, 31);

    // isof reasserted at (5,2), abandoning the partial frame
    c0 = ovalid_cnt;
    send(1'b1, 1'b0);
    while (!(tx == 5 && ty == 2)) send(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    repeat (4) idle();
    check("resof_frame_count", ovalid_cnt - c0, 27);

    check("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dog_hessian_window.md
# dog_hessian_window

Streaming stage that sits directly upstream of the edge-rejection stage. It accepts one DoG-layer pixel per valid cycle in raster order and buffers two image lines to form a 3×3 window. For every interior pixel it computes the second-derivative Hessian terms dxx, dyy and dxy as saturated signed 9-bit values, and presents them with the centre coordinates for the curvature test.

## Interface
- IMG_W, 640, pixels per line (≥3)
- IMG_H, 480, lines per frame (≥3)
- COORD_W, 10, coordinate width (2^COORD_W ≥ max(IMG_W, IMG_H))
- iclk  in  1  clock; all logic on rising edge
- irst  in  1  reset, synchronous, active-high
- ivalid  in  1  ipix valid this cycle
- isof  in  1  start of frame; qualified by ivalid, marks pixel (0,0)
- ipix  in  9 signed  DoG pixel
- ovalid  out  1  Hessian outputs valid (one-cycle strobe per interior pixel)
- odxx, odyy, odxy  out  9 signed each  saturated Hessian terms
- ox, oy  out  COORD_W each  centre-pixel column / row
- oeof  out  1  high together with ovalid for the last interior pixel of a frame

## Operation
- Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance on each ivalid cycle.
  - col wraps to 0 and row increments.
  - After (IMG_W-1, IMG_H-1), both wrap to (0,0).
- ivalid && isof forces the current pixel to (0,0), whatever the counter state. Mid-frame isof abandons the partial frame; no outputs are produced for abandoned windows beyond those already in the pipe.
- Two line buffers, IMG_W × 9 bits, indexed by col.
  - Read-before-write at the same address: LB1 returns row-1 and LB0 returns row-2.
  - On each ivalid, LB1[col] is copied to LB0[col] and ipix is written to LB1[col].
- The 3×3 window w[r][c] (r = 0 is the oldest row) shifts left by one column on each ivalid. The new right column is {LB0 out, LB1 out, ipix}.
- Window is complete when col ≥ 2 and row ≥ 2. Centre = (col-1, row-1).
- Border pixels never produce ovalid. Line-buffer contents are not reset, since stale data is only ever used for suppressed border windows.
- Arithmetic, in 12-bit signed intermediates:
  - dxx = w[1][2] + w[1][0] - 2·w[1][1]
  - dyy = w[2][1] + w[0][1] - 2·w[1][1]
  - dxy = (w[2][2] - w[2][0] - w[0][2] + w[0][0]) >>> 2, arithmetic shift, rounding toward -∞
- Each result saturates to [-256, 255] before output.
- oeof is asserted with ovalid when the centre is (IMG_W-2, IMG_H-2).
- No backpressure: the consumer must accept every ovalid strobe.

## Timing
- Two-stage pipeline after window capture:
  - S1 registers the raw sums plus valid and coordinates.
  - S2 registers the saturated outputs.
- Latency: a pixel accepted on cycle t that completes a window gives ovalid on cycle t+2, with ox = col-1 and oy = row-1 of that pixel.
- Pipeline stages advance every cycle. Valid bits propagate independently of ivalid, so input gaps never stall or duplicate outputs.
- Back-to-back ivalid gives back-to-back ovalid (throughput 1/cycle).
- Output count per frame is exactly (IMG_W-2)·(IMG_H-2).
- Reset values (cycle after irst high): ovalid = 0, oeof = 0, odxx = odyy = odxy = 0, ox = oy = 0, col = row = 0, window = 0, all pipeline valid bits 0.
- Reset mid-frame flushes in-flight results. The first pixel after reset is treated as (0,0) even without isof.
- Simultaneous irst and ivalid: reset wins and the pixel is dropped.

## Test plan
- IMG_W=8, IMG_H=6, constant pixel 37, continuous ivalid → 24 ovalid strobes, all odxx/odyy/odxy = 0, ox 1..6, oy 1..4 raster order, oeof only at (6,4), first ovalid 2 cycles after pixel (2,2).
- Same size, pixel = x·y → every output odxx = 0, odyy = 0, odxy = 1.
- Pixel = x² (x = 0..7) → odxx = 2, odyy = 0, odxy = 0 everywhere.
- Checkerboard of 255 / -256 → at centres holding 255, odxx = odyy = -256 (saturated from -1022); at centres holding -256, odxx = odyy = 255 (from 1022); odxy = 0 everywhere.
- Random ivalid gaps (~40% idle) with pixel = x·y → identical output sequence to the continuous run, ovalid exactly 2 cycles after each completing pixel.
- irst asserted mid-row 3, then a new frame; separately, isof reasserted at (5,2) → no stale outputs after reset, and outputs restart at centre (1,1) of the new frame.
